// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, instruction-memory request and IF/ID register with
// stall buffering and redirect kill of in-flight requests.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcSel,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic        pcStall,
  input  logic        ifidStall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] dinst,
  output logic [31:0] dpc,
  output logic        dvalid
);
  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, buf_q, buf_d;
  logic [31:0] dinst_q, dinst_d, dpc_q, dpc_d;
  logic        dvalid_q, dvalid_d;
  logic        redir, stall, kill_next;
  logic [31:0] tgt, pc_inc;
  assign redir     = (pcSel == 2'b01) || (pcSel == 2'b10);
  assign tgt       = {(pcSel == 2'b01) ? bpc[31:2] : jpc[31:2], 2'b00};
  assign stall     = pcStall | ifidStall;
  assign pc_inc    = pc_q + 32'd4;
  // An unanswered request must stay on the bus, so a redirect during it parks in KILL.
  assign kill_next = (state_q != HOLD) && !imemReady;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    dinst_d  = dinst_q;
    dpc_d    = dpc_q;
    dvalid_d = dvalid_q;
    if (redir) begin
      pc_d     = tgt;
      addr_d   = kill_next ? addr_q : tgt;
      state_d  = kill_next ? KILL : FETCH;
      dinst_d  = NOP_INST;
      dpc_d    = '0;
      dvalid_d = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imemReady && stall) begin
            buf_d   = imemData;
            state_d = HOLD;
          end else if (imemReady) begin
            dinst_d  = imemData;
            dpc_d    = pc_q;
            dvalid_d = 1'b1;
            pc_d     = pc_inc;
            addr_d   = pc_inc;
          end else if (!stall) begin
            dinst_d  = NOP_INST;
            dpc_d    = '0;
            dvalid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            dinst_d  = buf_q;
            dpc_d    = pc_q;
            dvalid_d = 1'b1;
            pc_d     = pc_inc;
            addr_d   = pc_inc;
            state_d  = FETCH;
          end
        end
        KILL: begin
          if (!ifidStall) begin
            dinst_d  = NOP_INST;
            dpc_d    = '0;
            dvalid_d = 1'b0;
          end
          if (imemReady) begin
            addr_d  = pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      buf_q    <= '0;
      dinst_q  <= NOP_INST;
      dpc_q    <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      buf_q    <= buf_d;
      dinst_q  <= dinst_d;
      dpc_q    <= dpc_d;
      dvalid_q <= dvalid_d;
    end
  end
  assign imemReq  = (state_q != HOLD);
  assign imemAddr = addr_q;
  assign dinst    = dinst_q;
  assign dpc      = dpc_q;
  assign dvalid   = dvalid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench; memory returns its own address as data.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst, pcStall, ifidStall, imemReady, imemReq, dvalid;
  logic [1:0]  pcSel;
  logic [31:0] bpc, jpc, imemAddr, imemData, dinst, dpc;
  int          checks = 0, errors = 0;
  logic [31:0] sb[$];
  logic [31:0] e_inst = NOP, e_pc = '0, epc = '0;
  logic        e_valid = 1'b0;
  always #5 clk = ~clk;
  assign imemData = imemAddr;
  fetch_stage dut (
    .clk(clk), .rst(rst), .pcSel(pcSel), .bpc(bpc), .jpc(jpc),
    .pcStall(pcStall), .ifidStall(ifidStall), .imemReq(imemReq),
    .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
    .dinst(dinst), .dpc(dpc), .dvalid(dvalid)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic r, input logic [31:0] a);
    chk("imemReq", 32'(imemReq), 32'(r));
    if (r) chk("imemAddr", imemAddr, a);
  endtask
  // kind: 0 = bubble, 1 = next scoreboard word delivered, 2 = IF/ID held
  task automatic cyc(input int kind);
    @(posedge clk);
    #1;
    if (kind == 0) begin
      e_inst = NOP; e_pc = '0; e_valid = 1'b0;
    end else if (kind == 1) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e_inst = sb.pop_front(); e_pc = e_inst; e_valid = 1'b1;
      end
    end
    chk("dinst", dinst, e_inst);
    chk("dpc", dpc, e_pc);
    chk("dvalid", 32'(dvalid), 32'(e_valid));
  endtask
  task automatic stream(input int n);
    repeat (n) begin
      req(1'b1, epc);
      sb.push_back(epc);
      cyc(1);
      epc += 32'd4;
    end
  endtask
  initial begin
    rst = 1'b1; pcSel = 2'b00; bpc = '0; jpc = '0;
    pcStall = 1'b0; ifidStall = 1'b0; imemReady = 1'b0;
    cyc(0); cyc(0);
    rst = 1'b0;
    req(1'b1, 32'h0);
    imemReady = 1'b1;
    stream(4);
    imemReady = 1'b0;
    repeat (3) begin req(1'b1, 32'h10); cyc(0); end
    imemReady = 1'b1;
    stream(4);
    ifidStall = 1'b1;
    req(1'b1, 32'h20);
    sb.push_back(32'h20);
    cyc(2); req(1'b0, '0);
    cyc(2); req(1'b0, '0);
    ifidStall = 1'b0;
    cyc(1);
    epc = 32'h24;
    stream(7);
    imemReady = 1'b0; pcSel = 2'b01; bpc = 32'h103;
    req(1'b1, 32'h40);
    cyc(0);
    pcSel = 2'b00;
    req(1'b1, 32'h40);
    cyc(0);
    req(1'b1, 32'h40);
    imemReady = 1'b1;
    cyc(0);
    epc = 32'h100;
    stream(2);
    ifidStall = 1'b1;
    req(1'b1, 32'h108);
    cyc(2); req(1'b0, '0);
    pcSel = 2'b10; jpc = 32'h200;
    cyc(0);
    pcSel = 2'b00; ifidStall = 1'b0;
    epc = 32'h200;
    stream(1);
    pcSel = 2'b11; bpc = 32'h500; jpc = 32'h600;
    stream(1);
    pcSel = 2'b00;
    pcStall = 1'b1;
    req(1'b1, epc);
    sb.push_back(epc);
    cyc(2); req(1'b0, '0);
    pcStall = 1'b0;
    cyc(1);
    epc += 32'd4;
    stream(1);
    imemReady = 1'b0; pcSel = 2'b01; bpc = 32'h300;
    cyc(0);
    pcSel = 2'b00;
    rst = 1'b1;
    cyc(0);
    rst = 1'b0;
    req(1'b1, 32'h0);
    imemReady = 1'b1;
    epc = '0;
    stream(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pcSel  input  2  next-PC select: 00 sequential, 01 branch target, 10 jump target, 11 treated as 00.
REQ-006 bpc  input  32  branch target address.
REQ-007 jpc  input  32  jump target address (JAL/JALR).
REQ-008 pcStall  input  1  hold PC.
REQ-009 ifidStall  input  1  hold IF/ID register.
REQ-010 imemReq  output  1  instruction-memory request.
REQ-011 imemAddr  output  32  request address, registered.
REQ-012 imemReady  input  1  memory accepts request and returns imemData in same cycle.
REQ-013 imemData  input  32  fetched instruction word, valid only when imemReq & imemReady.
REQ-014 dinst  output  32  IF/ID instruction, decode-stage input.
REQ-015 dpc  output  32  IF/ID PC of dinst.
REQ-016 dvalid  output  1  dinst is a real fetched instruction (0 = bubble).

Function
REQ-017 "Redirect" SHALL mean pcSel = 01 or 10; target = bpc or jpc with bits [1:0] forced to 00.
REQ-018 "Stall" SHALL mean pcStall | ifidStall.
REQ-019 States SHALL be FETCH, HOLD, KILL.
REQ-020 FETCH: imemReq = 1, imemAddr = pc.
REQ-021 HOLD: imemReq = 0; fetched word held in internal buffer buf.
REQ-022 KILL: imemReq = 1; imemAddr keeps the in-flight address; returned data discarded.
REQ-023 imemAddr SHALL not change while imemReq = 1 and imemReady = 0.
REQ-024 Redirect SHALL have priority over stall in every state.
REQ-025 Any redirect SHALL load pc <= target and IF/ID <= {dinst=NOP_INST, dpc=0, dvalid=0} in the same edge.
REQ-026 FETCH, ready, no redirect, no stall: IF/ID <= {imemData, pc, 1}; pc <= pc+4 (mod 2^32); stay FETCH.
REQ-027 FETCH, ready, no redirect, stall: buf <= imemData; IF/ID held; pc held; go HOLD.
REQ-028 FETCH, not ready, no redirect, no stall: IF/ID <= bubble; stay FETCH.
REQ-029 FETCH, not ready, no redirect, stall: IF/ID held; stay FETCH.
REQ-030 FETCH, ready, redirect: data discarded; stay FETCH; next imemAddr = target.
REQ-031 FETCH, not ready, redirect: go KILL; imemAddr unchanged.
REQ-032 HOLD, no redirect, no stall: IF/ID <= {buf, pc, 1}; pc <= pc+4; go FETCH.
REQ-033 HOLD, stall: all state held.
REQ-034 HOLD, redirect: buf dropped; go FETCH.
REQ-035 KILL, ready: data discarded; go FETCH with imemAddr <= pc; IF/ID bubble unless ifidStall.
REQ-036 KILL, not ready: IF/ID bubble unless ifidStall; further redirect updates pc only.
REQ-037 Every fetched word SHALL reach IF/ID exactly once, in address order, unless discarded by redirect.
REQ-038 Latency: zero-wait memory with no stall/redirect delivers one instruction per cycle; dinst appears one edge after imemReady.

Reset
REQ-039 On rst=1 at an edge: pc <= RESET_PC, imemAddr <= RESET_PC, state <= FETCH, buf <= 0, dinst <= NOP_INST, dpc <= 0, dvalid <= 0.
REQ-040 Reset SHALL override redirect, stall and any in-flight request (KILL/HOLD abandoned); imemReq = 1 in the first cycle after reset.

Verification
REQ-041 Reset, imemReady=1 always, data = addr: dinst 0x0,0x4,0x8... on consecutive cycles, dvalid=1, dpc = dinst.
REQ-042 imemReady low 3 cycles at pc=0x10, no stall: imemAddr stable 0x10, 3 bubbles (dvalid=0), then dinst=word@0x10, dpc=0x10.
REQ-043 ifidStall=1 for 2 cycles coinciding with ready at 0x20: HOLD entered, imemReq=0, IF/ID unchanged; after release dinst=word@0x20, then 0x24 fetched.
REQ-044 pcSel=01, bpc=0x103 while not ready at 0x40: KILL; 0x40 kept until ready, data dropped; next request 0x100; IF/ID shows NOP_INST, dvalid=0 until word@0x100.
REQ-045 pcSel=10, jpc=0x200 simultaneous with ifidStall=1 in HOLD: buffer dropped, IF/ID flushed to bubble, next imemAddr=0x200.
REQ-046 rst asserted during KILL: next cycle imemAddr=RESET_PC, imemReq=1, dinst=NOP_INST, dvalid=0.
